csr_reg: RTL and testbench

- Machine-mode CSR file for the RV32I core.
- Responder for the decode stage's CSR read address and the execute stage's CSR write request. Also serves a second read/write port for the interrupt controller (clint).
- Holds the 64-bit cycle and instret counters.
- Drives mstatus/mtvec/mepc/global-interrupt-enable to the clint.

---
 rtl/csr_reg_pkg.sv | 65 ++++++
 rtl/csr_counter64.sv | 47 ++++
 rtl/csr_reg.sv | 119 +++++++++++
 tb/tb_csr_reg.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/csr_reg_pkg.sv
// Shared CSR address map, write masks and write-port helpers for the machine-mode CSR file.
// Only addr[11:0] is decoded; callers slice the bus before using these helpers.
package csr_reg_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;  // MPIE | MIE
    localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;  // MPP hardwired to M-mode
    localparam logic [31:0] MISA_RESET    = 32'h4000_0100;

    typedef struct packed {
        logic        en;
        logic [11:0] addr;
        logic [31:0] data;
    } csr_wr_t;

    function automatic logic csr_writable(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] csr_wmask(input logic [11:0] addr, input logic [31:0] data);
        case (addr)
            CSR_MSTATUS:          return (data & MSTATUS_WMASK) | MSTATUS_FIXED;
            CSR_MTVEC, CSR_MEPC:  return {data[31:2], 2'b00};
            default:              return data;
        endcase
    endfunction

    function automatic logic csr_wr_hit(input csr_wr_t wr, input logic [11:0] addr);
        return wr.en && (wr.addr == addr);
    endfunction

    // Execute port wins over clint when both target the same address.
    function automatic logic [31:0] csr_wr_select(input csr_wr_t exe, input csr_wr_t clint,
                                                  input logic [11:0] addr,
                                                  input logic [31:0] cur);
        if (csr_wr_hit(exe, addr)) begin
            return exe.data;
        end else if (csr_wr_hit(clint, addr)) begin
            return clint.data;
        end
        return cur;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with increment enable and independent low/high word loads.
// A low-word load suppresses the increment; a high-word load blocks the carry that cycle.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_en,
    input  logic        lo_we,
    input  logic [31:0] lo_wdata,
    input  logic        hi_we,
    input  logic [31:0] hi_wdata,
    output logic [63:0] count
);

    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic [63:0] sum;

    assign sum   = {hi_q, lo_q} + 64'd1;
    assign count = {hi_q, lo_q};

    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (inc_en) begin
            lo_d = sum[31:0];
            hi_d = sum[63:32];
        end
        if (lo_we) begin
            lo_d = lo_wdata;
            hi_d = hi_q;
        end
        if (hi_we) begin
            hi_d = hi_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

endmodule

// File: rtl/csr_reg.sv
// Machine-mode CSR file: decode/execute port plus a clint port, with same-cycle write bypass
// on both read ports and 64-bit cycle/instret counters.
module csr_reg
    import csr_reg_pkg::*;
#(
    parameter logic [31:0] HART_ID  = 32'd0,
    parameter logic [31:0] MISA_VAL = MISA_RESET
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] csrr_addr_i,
    output logic [31:0] csr_rdata_o,
    input  logic        csrw_enable_i,
    input  logic [31:0] csrw_addr_i,
    input  logic [31:0] csrw_data_i,
    input  logic        clint_we_i,
    input  logic [31:0] clint_waddr_i,
    input  logic [31:0] clint_wdata_i,
    input  logic [31:0] clint_raddr_i,
    output logic [31:0] clint_rdata_o,
    input  logic        inst_retire_i,
    output logic        global_int_en_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic [31:0] mstatus_o
);

    csr_wr_t     exe_wr, clint_wr;
    logic [31:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [63:0] mcycle, minstret;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{csrr_addr_i[31:12], csrw_addr_i[31:12], clint_waddr_i[31:12],
                                clint_raddr_i[31:12]};

    // Writes to read-only/unimplemented addresses never raise en, so they also never bypass.
    always_comb begin
        exe_wr.en     = csrw_enable_i && csr_writable(csrw_addr_i[11:0]);
        exe_wr.addr   = csrw_addr_i[11:0];
        exe_wr.data   = csr_wmask(csrw_addr_i[11:0], csrw_data_i);
        clint_wr.en   = clint_we_i && csr_writable(clint_waddr_i[11:0]);
        clint_wr.addr = clint_waddr_i[11:0];
        clint_wr.data = csr_wmask(clint_waddr_i[11:0], clint_wdata_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q  <= MSTATUS_FIXED;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else begin
            mstatus_q  <= csr_wr_select(exe_wr, clint_wr, CSR_MSTATUS, mstatus_q);
            mie_q      <= csr_wr_select(exe_wr, clint_wr, CSR_MIE, mie_q);
            mtvec_q    <= csr_wr_select(exe_wr, clint_wr, CSR_MTVEC, mtvec_q);
            mscratch_q <= csr_wr_select(exe_wr, clint_wr, CSR_MSCRATCH, mscratch_q);
            mepc_q     <= csr_wr_select(exe_wr, clint_wr, CSR_MEPC, mepc_q);
            mcause_q   <= csr_wr_select(exe_wr, clint_wr, CSR_MCAUSE, mcause_q);
            mtval_q    <= csr_wr_select(exe_wr, clint_wr, CSR_MTVAL, mtval_q);
        end
    end

    csr_counter64 u_mcycle (
        .clk      (clk),
        .rst      (rst),
        .inc_en   (1'b1),
        .lo_we    (csr_wr_hit(exe_wr, CSR_MCYCLE) || csr_wr_hit(clint_wr, CSR_MCYCLE)),
        .lo_wdata (csr_wr_select(exe_wr, clint_wr, CSR_MCYCLE, 32'd0)),
        .hi_we    (csr_wr_hit(exe_wr, CSR_MCYCLEH) || csr_wr_hit(clint_wr, CSR_MCYCLEH)),
        .hi_wdata (csr_wr_select(exe_wr, clint_wr, CSR_MCYCLEH, 32'd0)),
        .count    (mcycle)
    );

    csr_counter64 u_minstret (
        .clk      (clk),
        .rst      (rst),
        .inc_en   (inst_retire_i),
        .lo_we    (csr_wr_hit(exe_wr, CSR_MINSTRET) || csr_wr_hit(clint_wr, CSR_MINSTRET)),
        .lo_wdata (csr_wr_select(exe_wr, clint_wr, CSR_MINSTRET, 32'd0)),
        .hi_we    (csr_wr_hit(exe_wr, CSR_MINSTRETH) || csr_wr_hit(clint_wr, CSR_MINSTRETH)),
        .hi_wdata (csr_wr_select(exe_wr, clint_wr, CSR_MINSTRETH, 32'd0)),
        .count    (minstret)
    );

    function automatic logic [31:0] csr_stored(input logic [11:0] addr);
        case (addr)
            CSR_MSTATUS:                 return mstatus_q;
            CSR_MISA:                    return MISA_VAL;
            CSR_MIE:                     return mie_q;
            CSR_MTVEC:                   return mtvec_q;
            CSR_MSCRATCH:                return mscratch_q;
            CSR_MEPC:                    return mepc_q;
            CSR_MCAUSE:                  return mcause_q;
            CSR_MTVAL:                   return mtval_q;
            CSR_MCYCLE, CSR_CYCLE:       return mcycle[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:     return mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:   return minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: return minstret[63:32];
            CSR_MHARTID:                 return HART_ID;
            default:                     return 32'd0;
        endcase
    endfunction

    always_comb begin
        csr_rdata_o   = csr_wr_select(exe_wr, clint_wr, csrr_addr_i[11:0],
                                      csr_stored(csrr_addr_i[11:0]));
        clint_rdata_o = csr_wr_select(exe_wr, clint_wr, clint_raddr_i[11:0],
                                      csr_stored(clint_raddr_i[11:0]));
    end

    assign mstatus_o       = mstatus_q;
    assign mtvec_o         = mtvec_q;
    assign mepc_o          = mepc_q;
    assign global_int_en_o = mstatus_q[3];

endmodule

// File: tb/tb_csr_reg.sv
// Directed bench for csr_reg: reset values, masks, bypass, write priority, counters and reset.
module tb_csr_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] csrr_addr_i, csr_rdata_o;
    logic        csrw_enable_i;
    logic [31:0] csrw_addr_i, csrw_data_i;
    logic        clint_we_i;
    logic [31:0] clint_waddr_i, clint_wdata_i, clint_raddr_i, clint_rdata_o;
    logic        inst_retire_i;
    logic        global_int_en_o;
    logic [31:0] mtvec_o, mepc_o, mstatus_o;

    int checks   = 0;
    int failures = 0;

    csr_reg dut (
        .clk             (clk),
        .rst             (rst),
        .csrr_addr_i     (csrr_addr_i),
        .csr_rdata_o     (csr_rdata_o),
        .csrw_enable_i   (csrw_enable_i),
        .csrw_addr_i     (csrw_addr_i),
        .csrw_data_i     (csrw_data_i),
        .clint_we_i      (clint_we_i),
        .clint_waddr_i   (clint_waddr_i),
        .clint_wdata_i   (clint_wdata_i),
        .clint_raddr_i   (clint_raddr_i),
        .clint_rdata_o   (clint_rdata_o),
        .inst_retire_i   (inst_retire_i),
        .global_int_en_o (global_int_en_o),
        .mtvec_o         (mtvec_o),
        .mepc_o          (mepc_o),
        .mstatus_o       (mstatus_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr, input string tag, input logic [31:0] exp);
        csrr_addr_i = addr;
        #1;
        check(tag, csr_rdata_o, exp);
    endtask

    task automatic crd(input logic [31:0] addr, input string tag, input logic [31:0] exp);
        clint_raddr_i = addr;
        #1;
        check(tag, clint_rdata_o, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        csrr_addr_i = '0; csrw_enable_i = 1'b0; csrw_addr_i = '0; csrw_data_i = '0;
        clint_we_i = 1'b0; clint_waddr_i = '0; clint_wdata_i = '0; clint_raddr_i = '0;
        inst_retire_i = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        rd(32'h300, "rst_mstatus", 32'h0000_1800);
        rd(32'h301, "rst_misa", 32'h4000_0100);
        rd(32'hF14, "rst_mhartid", 32'h0);
        rd(32'h340, "rst_mscratch", 32'h0);
        rd(32'hB00, "rst_mcycle", 32'h0);
        check("rst_gie", {31'd0, global_int_en_o}, 32'd0);
        check("rst_mstatus_o", mstatus_o, 32'h0000_1800);

        // 10 cycles, retire on every other one
        for (int i = 0; i < 10; i++) begin
            inst_retire_i = (i % 2 == 0);
            step();
        end
        inst_retire_i = 1'b0;
        rd(32'hB00, "mcycle_10", 32'd10);
        rd(32'hB02, "minstret_5", 32'd5);
        rd(32'hC02, "instret_alias", 32'd5);
        rd(32'hB82, "minstreth_0", 32'd0);

        // mstatus mask + bypass; registered outputs do not bypass
        csrw_enable_i = 1'b1; csrw_addr_i = 32'h300; csrw_data_i = 32'hFFFF_FFFF;
        rd(32'h300, "mstatus_bypass", 32'h0000_1888);
        crd(32'h300, "mstatus_bypass_clint", 32'h0000_1888);
        check("mstatus_o_nobypass", mstatus_o, 32'h0000_1800);
        step();
        csrw_enable_i = 1'b0;
        rd(32'h300, "mstatus_after", 32'h0000_1888);
        rd(32'hFFFF_F300, "upper_addr_ignored", 32'h0000_1888);
        check("mstatus_o_after", mstatus_o, 32'h0000_1888);
        check("gie_set", {31'd0, global_int_en_o}, 32'd1);

        // mcycle low/high loads, no carry on high-load cycle, carry on wrap
        csrw_enable_i = 1'b1; csrw_addr_i = 32'hB00; csrw_data_i = 32'hFFFF_FFFE;
        rd(32'hB00, "mcycle_lo_bypass", 32'hFFFF_FFFE);
        step();
        rd(32'hB00, "mcycle_lo_loaded", 32'hFFFF_FFFE);
        rd(32'hB80, "mcycleh_unchanged", 32'h0);
        csrw_addr_i = 32'hB80; csrw_data_i = 32'h0000_0001;
        step();
        csrw_enable_i = 1'b0;
        rd(32'hB00, "mcycle_lo_inc", 32'hFFFF_FFFF);
        rd(32'hB80, "mcycleh_loaded", 32'h1);
        step();
        rd(32'hB00, "mcycle_wrap_lo", 32'h0);
        rd(32'hB80, "mcycle_wrap_hi", 32'h2);
        step();
        rd(32'hB00, "mcycle_lo_1", 32'h1);
        rd(32'hB80, "mcycleh_2", 32'h2);
        rd(32'hC00, "cycle_alias", 32'h1);
        rd(32'hC80, "cycleh_alias", 32'h2);

        // Writes to read-only addresses are ignored and never bypass
        csrw_enable_i = 1'b1; csrw_addr_i = 32'hC00; csrw_data_i = 32'h0;
        clint_we_i = 1'b1; clint_waddr_i = 32'hF14; clint_wdata_i = 32'hFFFF_FFFF;
        rd(32'hF14, "ro_nobypass", 32'h0);
        crd(32'hC00, "ro_cycle_nobypass", 32'h1);
        step();
        csrw_enable_i = 1'b0; clint_we_i = 1'b0;
        rd(32'hB00, "cycle_write_ignored", 32'h2);
        rd(32'hF14, "mhartid_write_ignored", 32'h0);
        rd(32'h7C0, "unimpl_read", 32'h0);

        // Same-address collision: execute wins
        csrw_enable_i = 1'b1; csrw_addr_i = 32'h341; csrw_data_i = 32'h0000_1003;
        clint_we_i = 1'b1; clint_waddr_i = 32'h341; clint_wdata_i = 32'h0000_2000;
        crd(32'h341, "mepc_collide_bypass", 32'h0000_1000);
        step();
        rd(32'h341, "mepc_collide", 32'h0000_1000);
        check("mepc_o", mepc_o, 32'h0000_1000);

        // Different addresses: both applied
        csrw_addr_i = 32'h340; csrw_data_i = 32'h0000_00A5;
        clint_waddr_i = 32'h342; clint_wdata_i = 32'h8000_0007;
        rd(32'h342, "clint_bypass", 32'h8000_0007);
        step();
        csrw_enable_i = 1'b0; clint_we_i = 1'b0;
        rd(32'h340, "mscratch_both", 32'h0000_00A5);
        crd(32'h342, "mcause_both", 32'h8000_0007);

        // mtvec mask, registered output
        csrw_enable_i = 1'b1; csrw_addr_i = 32'h305; csrw_data_i = 32'h0000_1237;
        #1;
        check("mtvec_o_nobypass", mtvec_o, 32'h0);
        step();
        csrw_enable_i = 1'b0;
        check("mtvec_masked", mtvec_o, 32'h0000_1234);

        // Reset beats a simultaneous write
        csrw_enable_i = 1'b1; csrw_addr_i = 32'h305; csrw_data_i = 32'h0000_4000;
        inst_retire_i = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0; csrw_enable_i = 1'b0; inst_retire_i = 1'b0;
        #1;
        check("rst_mtvec", mtvec_o, 32'h0);
        check("rst_mepc", mepc_o, 32'h0);
        rd(32'hB00, "rst_mcycle_lo", 32'h0);
        rd(32'hB80, "rst_mcycle_hi", 32'h0);
        rd(32'hB02, "rst_minstret", 32'h0);
        rd(32'h300, "rst_mstatus2", 32'h0000_1800);
        check("rst_gie2", {31'd0, global_int_en_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
